inv_key_schedule: RTL and testbench

// - Reverse AES-128 key schedule for the decrypt datapath: loaded with the round-10 key, emits

---
 rtl/aes_pkg.sv | 34 +++
 rtl/inv_key_schedule_sub_bytes.sv | 55 +++++
 rtl/inv_key_schedule.sv | 159 +++++++++++++++
 tb/tb_inv_key_schedule.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants for the key-schedule datapath: sizes, round constants and the
// reverse-schedule FSM state encoding.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StSub,
    StMix
  } ks_state_e;

  // RCON[r] for r = 1..10; 0 outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/inv_key_schedule_sub_bytes.sv
// Single-byte AES SubBytes: forward S-box (inv_en_i=0) or inverse S-box (inv_en_i=1),
// built from GF(2^8) inversion plus the affine transform instead of lookup tables.
module inv_key_schedule_sub_bytes (
  input  logic       inv_en_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
  endfunction

  always_comb begin
    data_o = 8'h00;
    if (inv_en_i) begin
      data_o = gf_inv(inv_affine(data_i));
    end else begin
      data_o = affine(gf_inv(data_i));
    end
  end

endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key schedule: loaded with the round-10 key, emits round keys 10..0 over a
// valid/ready handshake. Optional KEY_CACHE_EN adds an 11-entry cache of emitted keys.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NR    = AES_NR,
  parameter int unsigned KEY_W = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_ready_i,
  output logic             key_valid_o,
  output logic [KEY_W-1:0] round_key_o,
  output logic [3:0]       round_o,
  output logic             busy_o,
  output logic             done_o,
  input  logic [3:0]       rd_idx_i,
  output logic [KEY_W-1:0] rd_key_o
);

  ks_state_e        state_q;
  logic [KEY_W-1:0] w_q;
  logic [3:0]       round_q;
  logic [1:0]       cnt_q;
  logic [3:0][7:0]  sub_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      t, rot;
  logic [7:0]       sbox_in, sbox_out;
  logic [KEY_W-1:0] w_mix;

  assign {w0, w1, w2, w3} = w_q;

  // w'3 = w3^w2 is the word the forward schedule fed through RotWord/SubWord.
  assign t   = w3 ^ w2;
  assign rot = {t[23:0], t[31:24]};

  always_comb begin
    sbox_in = rot[31:24];
    unique case (cnt_q)
      2'd0: sbox_in = rot[31:24];
      2'd1: sbox_in = rot[23:16];
      2'd2: sbox_in = rot[15:8];
      2'd3: sbox_in = rot[7:0];
    endcase
  end

  inv_key_schedule_sub_bytes u_sub_bytes (
    .inv_en_i (1'b0),
    .data_i   (sbox_in),
    .data_o   (sbox_out)
  );

  assign w_mix = {w0 ^ {sub_q[0], sub_q[1], sub_q[2], sub_q[3]} ^ {rcon(round_q), 24'h0},
                  w1 ^ w0, w2 ^ w1, w3 ^ w2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      w_q     <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      sub_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            w_q     <= key_in;
            round_q <= 4'(NR);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (key_ready_i) begin
            valid_q <= 1'b0;
            if (round_q == 4'd0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              cnt_q   <= 2'd0;
              state_q <= StSub;
            end
          end
        end
        StSub: begin
          sub_q[cnt_q] <= sbox_out;
          cnt_q        <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= StMix;
        end
        StMix: begin
          w_q     <= w_mix;
          round_q <= round_q - 4'd1;
          valid_q <= 1'b1;
          state_q <= StHold;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign key_valid_o = valid_q;
  assign round_key_o = w_q;
  assign round_o     = round_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef KEY_CACHE_EN
  logic [KEY_W-1:0] cache_q [0:NR];
  logic [KEY_W-1:0] rd_key_q;
  logic             cache_we;
  logic [3:0]       cache_idx;
  logic [KEY_W-1:0] cache_wd;

  // Capture each key on the same edge that makes it valid in HOLD.
  always_comb begin
    cache_we  = 1'b0;
    cache_idx = round_q;
    cache_wd  = w_q;
    if (state_q == StIdle && start_i) begin
      cache_we  = 1'b1;
      cache_idx = 4'(NR);
      cache_wd  = key_in;
    end else if (state_q == StMix) begin
      cache_we  = 1'b1;
      cache_idx = round_q - 4'd1;
      cache_wd  = w_mix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(NR); i++) cache_q[i] <= '0;
      rd_key_q <= '0;
    end else begin
      if (cache_we) cache_q[cache_idx] <= cache_wd;
      rd_key_q <= (rd_idx_i <= 4'(NR)) ? cache_q[rd_idx_i] : '0;
    end
  end

  assign rd_key_o = rd_key_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx_i;
  assign rd_key_o      = '0;
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 and all-zero key schedules, backpressure,
// ignored start pulses, mid-run reset, key cache reads and back-to-back runs.
module tb_inv_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [127:0] key_in;
  logic         key_ready_i;
  logic         key_valid_o;
  logic [127:0] round_key_o;
  logic [3:0]   round_o;
  logic         busy_o;
  logic         done_o;
  logic [3:0]   rd_idx_i;
  logic [127:0] rd_key_o;

  int total = 0;
  int bad   = 0;

  logic [127:0] fips_k [0:10];
  logic [127:0] zero_k [0:10];
  logic [127:0] exp_k  [0:10];
  logic         cache_on;

  inv_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .key_in      (key_in),
    .key_ready_i (key_ready_i),
    .key_valid_o (key_valid_o),
    .round_key_o (round_key_o),
    .round_o     (round_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_idx_i    (rd_idx_i),
    .rd_key_o    (rd_key_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for key_valid_o, then check the round index and key against exp_k.
  task automatic expect_key(input int r, output int waited);
    waited = 0;
    while (key_valid_o !== 1'b1 && waited < 12) begin
      step();
      waited++;
    end
    check($sformatf("valid_r%0d", r), key_valid_o, 1'b1);
    check($sformatf("round_r%0d", r), round_o, r);
    check($sformatf("key_r%0d", r), round_key_o, exp_k[r]);
  endtask

  // Full run with ready held high, checking every key and its arrival cycle.
  task automatic run_full(input logic [127:0] k10);
    int cyc;
    int n;
    key_in      = k10;
    key_ready_i = 1'b1;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    cyc     = 1;
    for (int r = 10; r >= 0; r--) begin
      expect_key(r, n);
      cyc += n;
      check($sformatf("arrive_r%0d", r), cyc, 1 + 6 * (10 - r));
      step();
      cyc++;
    end
    check("done_pulse", done_o, 1'b1);
    check("busy_end", busy_o, 1'b0);
    check("valid_end", key_valid_o, 1'b0);
  endtask

  initial begin
    int n;
    logic [127:0] held;

    fips_k[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    fips_k[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    fips_k[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    fips_k[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    fips_k[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    fips_k[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    fips_k[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    fips_k[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    fips_k[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    fips_k[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    fips_k[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

    zero_k[10] = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
    zero_k[9]  = 128'hb1d4d8e2_8a7db9da_1d7bb3de_4c664941;
    zero_k[8]  = 128'h0ef90333_3ba96138_97060a04_511dfa9f;
    zero_k[7]  = 128'h21751787_3550620b_acaf6b3c_c61bf09b;
    zero_k[6]  = 128'hec614b85_1425758c_99ff0937_6ab49ba7;
    zero_k[5]  = 128'h7f2e2b88_f8443e09_8dda7cbb_f34b9290;
    zero_k[4]  = 128'hee06da7b_876a1581_759e42b2_7e91ee2b;
    zero_k[3]  = 128'h90973450_696ccffa_f2f45733_0b0fac99;
    zero_k[2]  = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;
    zero_k[1]  = 128'h62636363_62636363_62636363_62636363;
    zero_k[0]  = 128'h0;

`ifdef KEY_CACHE_EN
    cache_on = 1'b1;
`else
    cache_on = 1'b0;
`endif

    rst_n       = 1'b0;
    start_i     = 1'b0;
    key_in      = '0;
    key_ready_i = 1'b0;
    rd_idx_i    = '0;
    repeat (2) step();
    check("rst_valid", key_valid_o, 1'b0);
    check("rst_key", round_key_o, 128'h0);
    check("rst_round", round_o, 4'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_rdkey", rd_key_o, 128'h0);
    rst_n = 1'b1;
    step();

    // FIPS run, then a different key started the cycle after done_o.
    exp_k = fips_k;
    run_full(fips_k[10]);
    step();
    check("done_clear", done_o, 1'b0);
    exp_k = zero_k;
    run_full(zero_k[10]);
    step();

    // start_i pulses in HOLD and SUB are ignored.
    exp_k       = fips_k;
    key_in      = fips_k[10];
    key_ready_i = 1'b1;
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
    key_ready_i = 1'b0;
    key_in      = zero_k[10];
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    check("ign_hold_round", round_o, 4'd10);
    check("ign_hold_key", round_key_o, fips_k[10]);
    key_ready_i = 1'b1;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int r = 9; r >= 0; r--) begin
      expect_key(r, n);
      step();
    end
    check("ign_done", done_o, 1'b1);
    step();

    // Backpressure at round 9, then reset during MIX of round 5.
    key_in      = fips_k[10];
    key_ready_i = 1'b1;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    expect_key(10, n);
    step();
    key_ready_i = 1'b0;
    expect_key(9, n);
    held = round_key_o;
    repeat (7) step();
    check("bp_valid", key_valid_o, 1'b1);
    check("bp_round", round_o, 4'd9);
    check("bp_key", round_key_o, held);
    check("bp_busy", busy_o, 1'b1);
    key_ready_i = 1'b1;
    step();
    expect_key(8, n);
    check("bp_gap8", n + 1, 6);
    for (int r = 7; r >= 5; r--) begin
      step();
      expect_key(r, n);
    end
    step();
    repeat (4) step();
    check("mix_busy", busy_o, 1'b1);
    check("mix_valid", key_valid_o, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", key_valid_o, 1'b0);
    check("arst_key", round_key_o, 128'h0);
    check("arst_round", round_o, 4'd0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_done", done_o, 1'b0);
    check("arst_rdkey", rd_key_o, 128'h0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_valid", key_valid_o, 1'b0);
    check("post_rst_busy", busy_o, 1'b0);

    exp_k = fips_k;
    run_full(fips_k[10]);
    step();

    // Cache read-back (zero when the cache is compiled out).
    rd_idx_i = 4'd0;
    step();
    check("cache_0", rd_key_o, cache_on ? fips_k[0] : 128'h0);
    rd_idx_i = 4'd5;
    step();
    check("cache_5", rd_key_o, cache_on ? fips_k[5] : 128'h0);
    rd_idx_i = 4'd10;
    step();
    check("cache_10", rd_key_o, cache_on ? fips_k[10] : 128'h0);
    rd_idx_i = 4'd12;
    step();
    check("cache_12", rd_key_o, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
